// File: rtl/trashbin_bus_pkg.sv
// Shared definitions for the two-requester memory bus arbiter.
package trashbin_bus_pkg;

    // Bus ownership: nobody, or a requester holding a locked burst.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } bus_state_t;

    // Requester indices.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // True when any address bit above the RAM word range is set.
    function automatic logic addr_oob(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker with a per-input enable mask.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] eff;

    // One-hot grant; on contention the input not granted last wins.
    always_comb begin
        eff = req & mask;
        gnt = '0;
        case (eff)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter between CPU (0) and DMA/loader (1) onto a single-port RAM,
// with locked bursts bounded by MAX_BURST and out-of-range rejection.
module memory_bus_arbiter
    import trashbin_bus_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned RAM_AW    = 14
) (
    input  logic              CoreClock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              We0,
    input  logic              Lock0,
    input  logic [31:0]       Addr0,
    input  logic [31:0]       WData0,
    output logic              Gnt0,
    output logic              RValid0,
    output logic [31:0]       RData0,
    output logic              Err0,
    input  logic              Req1,
    input  logic              We1,
    input  logic              Lock1,
    input  logic [31:0]       Addr1,
    input  logic [31:0]       WData1,
    output logic              Gnt1,
    output logic              RValid1,
    output logic [31:0]       RData1,
    output logic              Err1,
    output logic [RAM_AW-1:0] RamAddr,
    output logic [31:0]       RamWData,
    output logic              RamWe,
    input  logic [31:0]       RamRData
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    bus_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        last_q, last_d;
    logic        rvalid_q, rd_owner_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        own0_active, own1_active, own_sel_active;
    logic [1:0]  mask, gnt_raw, gnt;
    logic        any_gnt, sel, sel_we, sel_lock, other_req, oob, rd_issue;
    logic [31:0] sel_addr, sel_wdata;

    rr_arbiter2 u_rr (
        .req  ({Req1, Req0}),
        .last (last_q),
        .mask (mask),
        .gnt  (gnt_raw)
    );

    // Grant masking, requester mux and RAM-side drive.
    always_comb begin
        own0_active = (state_q == OWN0) && Req0;
        own1_active = (state_q == OWN1) && Req1;
        // An owner that dropped Req releases the bus in the same cycle.
        mask        = own0_active ? 2'b01 : (own1_active ? 2'b10 : 2'b11);
        gnt         = Reset ? 2'b00 : gnt_raw;
        any_gnt     = |gnt;
        sel         = gnt[1] ? REQ_DMA : (gnt[0] ? REQ_CPU : last_q);
        sel_addr    = sel ? Addr1  : Addr0;
        sel_wdata   = sel ? WData1 : WData0;
        sel_we      = sel ? We1    : We0;
        sel_lock    = sel ? Lock1  : Lock0;
        other_req   = sel ? Req0   : Req1;
        own_sel_active = sel ? own1_active : own0_active;
        oob         = addr_oob(sel_addr, RAM_AW);
        Gnt0        = gnt[0];
        Gnt1        = gnt[1];
        Err0        = gnt[0] && oob;
        Err1        = gnt[1] && oob;
        RamAddr     = sel_addr[RAM_AW+1:2];
        RamWData    = sel_wdata;
        RamWe       = any_gnt && sel_we && !oob;
        rd_issue    = any_gnt && !sel_we && !oob;
    end

    // Ownership FSM next state, burst counter and round-robin pointer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CW'(1);
        if (any_gnt) begin
            last_d = sel;
            if (own_sel_active) begin
                if (!sel_lock || (cnt_inc == MAX_CNT && other_req)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (sel_lock && (MAX_BURST > 1 || !other_req)) begin
                state_d = sel ? OWN1 : OWN0;
                cnt_d   = CW'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (!own0_active && !own1_active) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State registers, read-return tracking and read data hold.
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            rvalid_q   <= 1'b0;
            rd_owner_q <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            rvalid_q   <= rd_issue;
            rd_owner_q <= sel;
            if (rvalid_q && !rd_owner_q) rdata0_q <= RamRData;
            if (rvalid_q &&  rd_owner_q) rdata1_q <= RamRData;
        end
    end

    // Read return: RAM data passes through in the valid cycle, held otherwise.
    always_comb begin
        RValid0 = rvalid_q && !rd_owner_q && !Reset;
        RValid1 = rvalid_q &&  rd_owner_q && !Reset;
        RData0  = RValid0 ? RamRData : rdata0_q;
        RData1  = RValid1 ? RamRData : rdata1_q;
    end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed self-checking bench for memory_bus_arbiter with a 1-cycle-latency RAM model.
module tb_memory_bus_arbiter;

    logic        CoreClock = 1'b0;
    logic        Reset;
    logic        Req0, We0, Lock0, Req1, We1, Lock1;
    logic [31:0] Addr0, WData0, Addr1, WData1;
    logic        Gnt0, RValid0, Err0, Gnt1, RValid1, Err1;
    logic [31:0] RData0, RData1;
    logic [13:0] RamAddr;
    logic [31:0] RamWData, RamRData;
    logic        RamWe;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:16383];

    memory_bus_arbiter #(.MAX_BURST(8), .RAM_AW(14)) dut (
        .CoreClock(CoreClock), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Lock0(Lock0), .Addr0(Addr0), .WData0(WData0),
        .Gnt0(Gnt0), .RValid0(RValid0), .RData0(RData0), .Err0(Err0),
        .Req1(Req1), .We1(We1), .Lock1(Lock1), .Addr1(Addr1), .WData1(WData1),
        .Gnt1(Gnt1), .RValid1(RValid1), .RData1(RData1), .Err1(Err1),
        .RamAddr(RamAddr), .RamWData(RamWData), .RamWe(RamWe), .RamRData(RamRData)
    );

    always #5 CoreClock = ~CoreClock;

    // RAM model: synchronous write, registered read.
    always @(posedge CoreClock) begin
        if (RamWe) mem[RamAddr] <= RamWData;
        RamRData <= mem[RamAddr];
    end

    task automatic idle_inputs();
        Req0 = 0; We0 = 0; Lock0 = 0; Addr0 = '0; WData0 = '0;
        Req1 = 0; We1 = 0; Lock1 = 0; Addr1 = '0; WData1 = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CoreClock); #1;
            total++; if (Gnt0 !== 1'b0 || Gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt cyc=%0d got=%b%b want=00", i, Gnt1, Gnt0); end
            total++; if (RamWe !== 1'b0 || RValid0 !== 1'b0 || RValid1 !== 1'b0) begin bad++; $display("FAIL reset_outs cyc=%0d we=%b rv=%b%b want 0", i, RamWe, RValid1, RValid0); end
            total++; if (RData0 !== 32'h0 || RData1 !== 32'h0) begin bad++; $display("FAIL reset_rdata cyc=%0d got=%h/%h want=0", i, RData0, RData1); end
        end
        @(negedge CoreClock);
        Reset = 0;
        #1;
        total++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin bad++; $display("FAIL reset_first_gnt got=%b%b want=01", Gnt1, Gnt0); end
        @(negedge CoreClock);
        idle_inputs();
    endtask

    task automatic test_read();
        @(negedge CoreClock);
        Req0 = 1; We0 = 0; Addr0 = 32'h0000_0010;
        #1;
        total++; if (Gnt0 !== 1'b1) begin bad++; $display("FAIL read_gnt got=%b want=1", Gnt0); end
        total++; if (RamAddr !== 14'd4 || RamWe !== 1'b0) begin bad++; $display("FAIL read_ram addr=%0d we=%b want addr=4 we=0", RamAddr, RamWe); end
        @(negedge CoreClock);
        Req0 = 0;
        #1;
        total++; if (RValid0 !== 1'b1 || RValid1 !== 1'b0) begin bad++; $display("FAIL read_rvalid got=%b%b want=01", RValid1, RValid0); end
        total++; if (RData0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_rdata got=%h want=deadbeef", RData0); end
        @(negedge CoreClock); #1;
        total++; if (RValid0 !== 1'b0 || RData0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_hold rv=%b data=%h want rv=0 data=deadbeef", RValid0, RData0); end
    endtask

    task automatic test_round_robin();
        // Last grant went to 0, so requester 1 leads.
        @(negedge CoreClock);
        Req0 = 1; We0 = 1; Addr0 = 32'h0000_0020; WData0 = 32'h1234_5678;
        Req1 = 1; We1 = 0; Addr1 = 32'h0000_0020;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge CoreClock);
            #1;
            total++; if (Gnt1 !== ((i % 2) == 0) || Gnt0 !== ((i % 2) == 1)) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b%b want=%b%b", i, Gnt1, Gnt0, (i % 2) == 0, (i % 2) == 1); end
            total++; if (RamWe !== ((i % 2) == 1)) begin bad++; $display("FAIL rr_we cyc=%0d got=%b want=%b", i, RamWe, (i % 2) == 1); end
            total++; if (RValid1 !== ((i % 2) == 1)) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b want=%b", i, RValid1, (i % 2) == 1); end
            if ((i % 2) == 1) begin
                total++; if (RData1 !== ((i == 1) ? 32'h0 : 32'h1234_5678)) begin bad++; $display("FAIL rr_rdata cyc=%0d got=%h", i, RData1); end
            end
        end
        @(negedge CoreClock);
        idle_inputs();
    endtask

    task automatic test_burst();
        @(negedge CoreClock);
        Req0 = 1; We0 = 0; Addr0 = 32'h0;
        Req1 = 1; We1 = 0; Lock1 = 1; Addr1 = 32'h0000_0020;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge CoreClock);
            #1;
            if (i < 8) begin
                total++; if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0) begin bad++; $display("FAIL burst_gnt1 cyc=%0d got=%b%b want=10", i, Gnt1, Gnt0); end
            end else begin
                total++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin bad++; $display("FAIL burst_release got=%b%b want=01", Gnt1, Gnt0); end
            end
        end
        @(negedge CoreClock);
        idle_inputs();
    endtask

    task automatic test_range_err();
        @(negedge CoreClock);
        Req0 = 1; We0 = 1; Addr0 = 32'h0001_0000; WData0 = 32'hBAD0_BAD0;
        #1;
        total++; if (Gnt0 !== 1'b1 || Err0 !== 1'b1 || Err1 !== 1'b0) begin bad++; $display("FAIL err_wr gnt=%b err=%b%b want gnt=1 err=01", Gnt0, Err1, Err0); end
        total++; if (RamWe !== 1'b0) begin bad++; $display("FAIL err_wr_we got=%b want=0", RamWe); end
        @(negedge CoreClock);
        We0 = 0; Addr0 = 32'h8000_0000;
        #1;
        total++; if (Gnt0 !== 1'b1 || Err0 !== 1'b1) begin bad++; $display("FAIL err_rd gnt=%b err=%b want 1/1", Gnt0, Err0); end
        total++; if (RValid0 !== 1'b0) begin bad++; $display("FAIL err_wr_rvalid got=%b want=0", RValid0); end
        @(negedge CoreClock);
        Req0 = 0; Req1 = 1; We1 = 0; Addr1 = 32'h0000_FFFC;
        #1;
        total++; if (RValid0 !== 1'b0) begin bad++; $display("FAIL err_rd_rvalid got=%b want=0", RValid0); end
        total++; if (Gnt1 !== 1'b1 || Err1 !== 1'b0 || RamAddr !== 14'h3FFF) begin bad++; $display("FAIL top_word gnt=%b err=%b addr=%h want 1/0/3fff", Gnt1, Err1, RamAddr); end
        @(negedge CoreClock);
        idle_inputs();
        #1;
        total++; if (RValid1 !== 1'b1 || Err1 !== 1'b0) begin bad++; $display("FAIL top_word_rvalid rv=%b err=%b want 1/0", RValid1, Err1); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge CoreClock);
        Req1 = 1; We1 = 0; Lock1 = 1; Addr1 = 32'h0000_0010;
        #1;
        total++; if (Gnt1 !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b want=1", Gnt1); end
        @(negedge CoreClock);
        Reset = 1; Req1 = 0; Lock1 = 0;
        #1;
        total++; if (RValid1 !== 1'b0 || Gnt1 !== 1'b0) begin bad++; $display("FAIL mid_reset rv=%b gnt=%b want 0/0", RValid1, Gnt1); end
        @(negedge CoreClock);
        Reset = 0; Req0 = 1; Req1 = 1;
        #1;
        total++; if (RValid1 !== 1'b0) begin bad++; $display("FAIL mid_after_rvalid got=%b want=0", RValid1); end
        total++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b%b want=01", Gnt1, Gnt0); end
        @(negedge CoreClock);
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEAD_BEEF;
        Reset = 1;
        idle_inputs();
        Req0 = 1; Req1 = 1;
        test_reset();
        test_read();
        test_round_robin();
        test_burst();
        test_range_err();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
